// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch front end.
// Holds the default fetch entry layout and the PC step.
package cpu_types_pkg;

    localparam int XLEN = 32;
    localparam int PC_INC = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer between instruction memory and decode.
// Flush empties it in one cycle; storage keeps stale contents.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    output entry_t        rdata,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Fetch stage with a prefetch queue ahead of decode.
// Owns the fetch PC; redirect flushes the queue and refetches.
module fetch_prefetch_stage
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imemREN,
    output logic [ADDR_W-1:0]  imemaddr,
    input  logic               ihit,
    input  logic [INSTR_W-1:0] imemload,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_npc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CW-1:0]      count
);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic              push;
    logic              pop;
    entry_t            wdata;
    entry_t            head;

    assign imemREN   = !RST && !redirect && (count < CW'(DEPTH));
    assign imemaddr  = fetch_pc;
    assign push      = imemREN && ihit;
    assign out_valid = !RST && (count != '0);
    assign pop       = out_valid && out_ready;

    assign wdata.pc    = fetch_pc;
    assign wdata.instr = imemload;

    assign out_pc    = head.pc;
    assign out_npc   = head.pc + ADDR_W'(PC_INC);
    assign out_instr = head.instr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~ADDR_W'(3);
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .flush (redirect),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

endmodule

// File: doc/fetch_prefetch_stage.md
# fetch_prefetch_stage

Parametrised successor to the single-register fetch stage: owns the fetch PC, issues instruction-memory reads and buffers returned instructions in a DEPTH-entry prefetch queue ahead of decode. Decode drains the queue through a valid/ready handshake, so an instruction-memory stall no longer freezes decode and a decode stall no longer blocks fetch until the queue fills. Sits between the instruction cache port and the fetch/decode pipeline latch; branch/jump resolution redirects it and flushes the queue.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, ≥ 2
- RESET_PC, 0, fetch PC after reset; low two bits must be 0
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- imemREN  out  1  instruction read request
- imemaddr  out  ADDR_W  read address (= fetch PC)
- ihit  in  1  read complete this cycle; imemload valid
- imemload  in  INSTR_W  read data
- redirect  in  1  control-flow change from execute; flush and refetch
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  ADDR_W  PC of head instruction
- out_npc  out  ADDR_W  out_pc + 4 (mod 2^ADDR_W)
- out_instr  out  INSTR_W  head instruction
- count  out  $clog2(DEPTH)+1  entries currently queued

## Operation
- State: fetch_pc, queue storage, rd_ptr, wr_ptr, count.
- imemREN = !RST && !redirect && (count < DEPTH). imemaddr = fetch_pc always.
- push = imemREN && ihit: write {fetch_pc, imemload} at wr_ptr, wr_ptr++, fetch_pc += 4 (wraps modulo 2^ADDR_W).
- pop = out_valid && out_ready: rd_ptr++.
- count next = count + push − pop; push and pop in the same cycle leave count unchanged.
- Full (count == DEPTH): imemREN low, so no push; a pop that cycle frees a slot, request resumes next cycle (no same-cycle refill).
- ihit while imemREN low (full, redirect, reset) is ignored: no push, fetch_pc unchanged.
- redirect (highest priority after RST): next cycle fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}, count = 0, rd_ptr = wr_ptr = 0. Concurrent push and pop are discarded. out_* during the redirect cycle reflect old head; decode must ignore them (it is itself being flushed).
- Empty: out_valid = 0; out_pc/out_npc/out_instr undefined-but-stable (hold stale storage), never X after reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset (RST high at an edge): fetch_pc = RESET_PC, count = 0, pointers 0. While RST high: imemREN = 0, out_valid = 0, imemaddr = RESET_PC after first edge.
- First request: imemREN high in the first cycle RST is low.
- Fetch-to-decode latency: instruction returned with ihit in cycle N is on out_* with out_valid = 1 in cycle N+1 (no bypass).
- Redirect latency: redirect in cycle N → imemaddr = redirect_pc, imemREN = 1 in cycle N+1; first instruction visible no earlier than N+2.
- Sustained throughput: one instruction per cycle when ihit is continuously high and decode continuously ready.
- imemaddr and imemREN stable while waiting for ihit (no spurious address change mid-miss).

## Structure
- Shared cpu_types_pkg additions: fetch_entry_t struct {pc, instr}; localparam PC_INC = 4.
- One sub-module: fetch_fifo (parametrised circular buffer, DEPTH × fetch_entry_t, push/pop/flush, count output). Top module holds fetch_pc, request logic and redirect priority.

## Test plan
- Reset: RESET_PC=0x100, hold RST 3 cycles → imemREN=0, out_valid=0, count=0; release → imemaddr=0x100, imemREN=1.
- Streaming: ihit=1, out_ready=1 constantly, imemload = address → out_pc sequence 0x100, 0x104, 0x108… one per cycle from cycle 2, count stays 1.
- Fill: out_ready=0, ihit=1, DEPTH=4 → count reaches 4, imemREN drops, imemaddr=0x110 held; one pop → count 3, imemREN=1 next cycle.
- Miss stall: ihit low 5 cycles at 0x104 → imemaddr stays 0x104, no push, queued head still drains.
- Redirect: queue holding 3 entries, redirect=1 with redirect_pc=0x2003 → next cycle count=0, out_valid=0, imemaddr=0x2000; ihit during redirect cycle not queued.
- Wrap: RESET_PC=0xFFFFFFFC, ihit=1 → second fetch at 0x00000000; out_npc of first entry = 0x00000000.
